median_stream_10: RTL and testbench
===================================

// Module: median_stream_10
// PURPOSE
//   Streaming front/back end for the 10-input median/sort function: accepts one
//   32-bit word per cycle over valid/ready and gathers a frame of N words.
//   Sorts the frame in place with a sequential odd-even transposition network
//   and streams the sorted frame out one word per beat, flagging the median pair.
//   Sits between serial producers/consumers and the sort datapath where a
//   10-wide parallel port is unavailable.
// PARAMETERS
//   N  10  frame length in words; N >= 2, N even
//   W  32  data width in bits; unsigned compare
// PORTS
//   clk         in   1          clock; all state updates on posedge
//   rst         in   1          asynchronous, active-high reset
//   in_valid    in   1          in_data valid
//   in_ready    out  1          block accepts a word this cycle
//   in_data     in   W          frame element
//   out_valid   out  1          out_data valid
//   out_ready   in   1          consumer accepts out_data this cycle
//   out_data    out  W          sorted element, ascending
//   out_idx     out  clog2(N)   rank of out_data within the frame, 0..N-1
//   out_median  out  1          out_idx == N/2-1 or N/2 (median pair)
//   out_last    out  1          out_idx == N-1
// BEHAVIOUR
//   Reset (async assert, sync to clk on release): state=LOAD, wr_cnt=0,
//     pass_cnt=0, rd_idx=0, buf[*]=0. Outputs: in_ready=1, out_valid=0,
//     out_data=0, out_idx=0, out_median=0, out_last=0.
//   States: LOAD -> SORT -> DRAIN -> LOAD.
//   LOAD: in_ready=1, out_valid=0. On in_valid&&in_ready: buf[wr_cnt]<=in_data,
//     wr_cnt++. Accepting word N-1 moves to SORT and sets wr_cnt=0, pass_cnt=0.
//   SORT: in_ready=0, out_valid=0. Exactly N cycles, one pass per cycle.
//     Even pass_cnt: compare-exchange (0,1),(2,3),...,(N-2,N-1).
//     Odd pass_cnt:  compare-exchange (1,2),(3,4),...,(N-3,N-2).
//     Exchange only if buf[i] > buf[i+1]; ties leave both words in place.
//     After pass N-1: move to DRAIN with rd_idx=0.
//   DRAIN: in_ready=0, out_valid=1, out_data=buf[rd_idx], out_idx=rd_idx.
//     out_median and out_last are combinational from rd_idx.
//     On out_valid&&out_ready: rd_idx++. Handshake on rd_idx==N-1 moves to
//     LOAD with rd_idx=0.
//     out_valid stays high and out_data stays stable while out_ready=0.
//   Latency: last input accepted at edge t; out_valid first high after edge
//     t+N (N SORT cycles). One frame in flight at a time; no LOAD/DRAIN overlap.
//   in_valid is ignored outside LOAD; out_ready is ignored outside DRAIN.
//   Reset mid-frame (any state) discards the partial/sorted frame; next accepted
//     word is element 0 of a new frame.
//   Outputs are registered or decoded from registered state only; no input-to-
//     output combinational path except none (in_ready depends on state only).
// TESTING
//   Frame 9,8,...,0, out_ready=1 -> out 0..9, out_idx 0..9; median on 4,5;
//     out_last on 9; out_valid first high N cycles after last input accept.
//   Frame 5,5,5,1,1,9,9,0,0,5 -> out 0,0,1,1,5,5,5,5,9,9; median words both 5.
//   Extremes: FFFFFFFF,0,80000000,7FFFFFFF,1,... -> unsigned ascending;
//     FFFFFFFF emitted last.
//   out_ready toggling 1,0,0,1,... in DRAIN -> no drop or duplicate;
//     out_data stable while stalled; in_ready=0 throughout SORT/DRAIN.
//   rst pulse at SORT pass 3, then new frame 10..19 -> out 10..19;
//     no stale words from the aborted frame.
//   Back-to-back frames with in_valid held high -> in_ready returns to 1 the
//     cycle after the out_last handshake; second frame sorted correctly.

Source files
------------

// File: rtl/median_stream_10.sv
// Streaming wrapper around a sequential odd-even transposition sort: gathers an
// N-word frame over valid/ready, sorts it in N passes, then streams it out ascending.
module median_stream_10 #(
    parameter int N = 10,
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    out_median,
    output logic                    out_last
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] MED_LO   = IW'(N / 2 - 1);
    localparam logic [IW-1:0] MED_HI   = IW'(N / 2);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SORT,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];

    // Results of one even pass and one odd pass over the current frame.
    logic [W-1:0]    even_mem [N];
    logic [W-1:0]    odd_mem  [N];

    genvar gi;
    generate
        for (gi = 0; gi < N / 2; gi++) begin : g_even
            logic swap;
            assign swap               = mem_q[2*gi] > mem_q[2*gi+1];
            assign even_mem[2*gi]     = swap ? mem_q[2*gi+1] : mem_q[2*gi];
            assign even_mem[2*gi+1]   = swap ? mem_q[2*gi]   : mem_q[2*gi+1];
        end

        for (gi = 0; gi < N / 2 - 1; gi++) begin : g_odd
            logic swap;
            assign swap               = mem_q[2*gi+1] > mem_q[2*gi+2];
            assign odd_mem[2*gi+1]    = swap ? mem_q[2*gi+2] : mem_q[2*gi+1];
            assign odd_mem[2*gi+2]    = swap ? mem_q[2*gi+1] : mem_q[2*gi+2];
        end
    endgenerate

    // End words have no partner on odd passes.
    assign odd_mem[0]   = mem_q[0];
    assign odd_mem[N-1] = mem_q[N-1];

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        pass_cnt_d = pass_cnt_q;
        rd_idx_d   = rd_idx_q;
        mem_d      = mem_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_cnt_q] = in_data;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d    = ST_SORT;
                        wr_cnt_d   = '0;
                        pass_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IW'(1);
                    end
                end
            end

            ST_SORT: begin
                mem_d = pass_cnt_q[0] ? odd_mem : even_mem;
                if (pass_cnt_q == LAST_IDX) begin
                    state_d    = ST_DRAIN;
                    pass_cnt_d = '0;
                    rd_idx_d   = '0;
                end else begin
                    pass_cnt_d = pass_cnt_q + IW'(1);
                end
            end

            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            wr_cnt_q   <= '0;
            pass_cnt_q <= '0;
            rd_idx_q   <= '0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            rd_idx_q   <= rd_idx_d;
            mem_q      <= mem_d;
        end
    end

    // Output side is decoded purely from registered state and is held at zero
    // whenever no sorted word is being presented.
    logic draining;
    assign draining   = (state_q == ST_DRAIN);
    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = draining;
    assign out_data   = draining ? mem_q[rd_idx_q] : '0;
    assign out_idx    = draining ? rd_idx_q : '0;
    assign out_median = draining && ((rd_idx_q == MED_LO) || (rd_idx_q == MED_HI));
    assign out_last   = draining && (rd_idx_q == LAST_IDX);

endmodule

// File: tb/tb_median_stream_10.sv
// Randomized and directed bench for median_stream_10 against a frame-level
// reference model (collect N words, full sort, wait N cycles, stream out).
module tb_median_stream_10;

    localparam int N = 10;
    localparam int W = 32;

    typedef logic [W-1:0] frame_t [N];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [3:0]    out_idx;
    logic          out_median;
    logic          out_last;

    median_stream_10 #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_median (out_median),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] collect_q [$];
    logic [W-1:0] sorted [N];
    bit           busy = 0;
    int           wait_cnt = 0;
    int           rd = 0;
    int           frames_out = 0;
    logic [W-1:0] lit_q [$];

    function automatic void sort_frame();
        logic [W-1:0] t;
        for (int i = 0; i < N; i++) sorted[i] = collect_q[i];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (sorted[j] > sorted[j+1]) begin
                    t = sorted[j]; sorted[j] = sorted[j+1]; sorted[j+1] = t;
                end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
            chk("rst_out_median", {31'd0, out_median}, 32'd0);
            chk("rst_out_last", {31'd0, out_last}, 32'd0);
            collect_q.delete();
            busy = 0; wait_cnt = 0; rd = 0;
        end else begin
            bit exp_v;
            exp_v = busy && (wait_cnt >= N);
            chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            chk("out_data", out_data, exp_v ? sorted[rd] : 32'd0);
            chk("out_idx", {28'd0, out_idx}, exp_v ? rd : 0);
            chk("out_median", {31'd0, out_median},
                {31'd0, exp_v && (rd == N/2-1 || rd == N/2)});
            chk("out_last", {31'd0, out_last}, {31'd0, exp_v && (rd == N-1)});
            if (out_valid && out_ready && lit_q.size() > 0)
                chk("literal_word", out_data, lit_q.pop_front());

            // advance to the state after the coming rising edge
            if (!busy) begin
                if (in_valid) begin
                    collect_q.push_back(in_data);
                    if (collect_q.size() == N) begin
                        sort_frame();
                        collect_q.delete();
                        busy = 1; wait_cnt = 0; rd = 0;
                    end
                end
            end else if (wait_cnt < N) begin
                wait_cnt++;
            end else if (out_ready) begin
                if (rd == N - 1) begin
                    busy = 0; rd = 0; frames_out++;
                    $display("frame %0d drained", frames_out);
                end else begin
                    rd++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0
    int rdy_phase = 0;
    int gap_pct = 0;
    bit hold_valid = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 99) < 60);
            default: begin
                out_ready = (rdy_phase == 0);
                rdy_phase = (rdy_phase + 1) % 3;
            end
        endcase
    end

    task automatic send_frame(input frame_t f);
        for (int k = 0; k < N; k++) begin
            int guard = 0;
            bit acc = 0;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = f[k];
            while (!acc) begin
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 300) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept_timeout: word %0d not accepted", k);
                    acc = 1;
                end
            end
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: frame not drained");
        end
    endtask

    task automatic push_lit(input frame_t f);
        for (int k = 0; k < N; k++) lit_q.push_back(f[k]);
    endtask

    frame_t f, e;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // descending frame, latency check
        f = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        push_lit(e);
        send_frame(f);
        begin
            int cyc = 0;
            while (!out_valid && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("latency", cyc, N);
        end
        wait_idle();

        // duplicates
        f = '{32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'd9, 32'd9, 32'd0, 32'd0, 32'd5};
        e = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd9, 32'd9};
        push_lit(e);
        send_frame(f);
        wait_idle();

        // unsigned extremes, stalled drain
        rdy_mode = 2;
        f = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h1,
              32'h2, 32'hFFFFFFFE, 32'h80000001, 32'h3, 32'h7FFFFFFE};
        e = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h7FFFFFFE,
              32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
        push_lit(e);
        send_frame(f);
        wait_idle();
        rdy_mode = 0;

        // reset during SORT pass 3, then clean frame
        f = '{32'd99, 32'd98, 32'd97, 32'd96, 32'd95, 32'd94, 32'd93, 32'd92, 32'd91, 32'd90};
        send_frame(f);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        f = '{32'd19, 32'd12, 32'd15, 32'd10, 32'd18, 32'd11, 32'd17, 32'd13, 32'd16, 32'd14};
        e = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd19};
        push_lit(e);
        send_frame(f);
        wait_idle();

        // back-to-back frames with in_valid held high
        hold_valid = 1;
        for (int k = 0; k < N; k++) f[k] = $urandom;
        send_frame(f);
        for (int k = 0; k < N; k++) f[k] = $urandom_range(0, 7);
        send_frame(f);
        hold_valid = 0;
        in_valid = 1'b0;
        wait_idle();

        // randomized frames with gaps, random backpressure and frequent ties
        rdy_mode = 1;
        gap_pct = 30;
        for (int fr = 0; fr < 20; fr++) begin
            for (int k = 0; k < N; k++)
                f[k] = (fr % 2) ? $urandom_range(0, 5) : $urandom;
            send_frame(f);
        end
        wait_idle();
        rdy_mode = 0;
        gap_pct = 0;
        repeat (3) @(posedge clk);

        chk("literals_consumed", lit_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
